sraml_arbiter: RTL and testbench

SRAML_ARBITER -- requirements
Module: sraml_arbiter

---
 rtl/sraml_arbiter_pkg.sv | 18 +
 rtl/sraml_arbiter.sv | 127 ++++++++++++
 tb/tb_sraml_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sraml_arbiter_pkg.sv
// =============================================================================
// sraml_arbiter_pkg : shared CPU bus encodings (FSM states, bus owner IDs)
// Revision: 1.0
// =============================================================================
`default_nettype none

package sraml_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sraml_arbiter.sv
// =============================================================================
// sraml_arbiter : two-port sram-like bus arbiter, data priority with inst
//                 anti-starvation, one outstanding transaction at a time.
// Revision: 1.0
// =============================================================================
`default_nettype none

module sraml_arbiter
  import sraml_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok
);

  localparam int             CW      = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STARVE_MAX);

  logic [1:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic [CW-1:0] starve_q, starve_d;

  logic w_active;
  logic w_owner;
  logic w_addr_acc;
  logic w_data_fwd;

  function automatic logic pick_owner(input logic i_req, input logic d_req,
                                      input logic starved);
    return (d_req && !(starved && i_req)) ? OWN_DATA : OWN_INST;
  endfunction

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    w_owner  = owner_q;
    w_active = 1'b0;

    case (state_q)
      ST_IDLE: begin
        w_owner  = pick_owner(inst_req, data_req, starve_q == CNT_MAX);
        w_active = inst_req | data_req;
      end
      ST_ADDR: w_active = 1'b1;
      ST_DATA: ;
      default: state_d = ST_IDLE;
    endcase

    // Bus and handshakes stay quiet while reset is held, even in IDLE.
    if (!rst) w_active = 1'b0;

    w_addr_acc = w_active & m_addr_ok;
    w_data_fwd = (w_addr_acc & m_data_ok) |
                 (rst & (state_q == ST_DATA) & m_data_ok);

    if (w_active) begin
      owner_d = w_owner;
      if (m_addr_ok) begin
        state_d = m_data_ok ? ST_IDLE : ST_DATA;
        if (w_owner == OWN_INST) begin
          starve_d = '0;
        end else if (inst_req && (starve_q != CNT_MAX)) begin
          starve_d = starve_q + 1'b1;
        end
      end else begin
        state_d = ST_ADDR;
      end
    end else if ((state_q == ST_DATA) && m_data_ok) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_INST;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  assign m_req   = w_active;
  assign m_wr    = w_active & ((w_owner == OWN_DATA) ? data_wr : inst_wr);
  assign m_size  = w_active ? ((w_owner == OWN_DATA) ? data_size  : inst_size)  : 2'd0;
  assign m_addr  = w_active ? ((w_owner == OWN_DATA) ? data_addr  : inst_addr)  : 32'd0;
  assign m_wdata = w_active ? ((w_owner == OWN_DATA) ? data_wdata : inst_wdata) : 32'd0;

  assign inst_addr_ok = w_addr_acc & (w_owner == OWN_INST);
  assign data_addr_ok = w_addr_acc & (w_owner == OWN_DATA);
  assign inst_data_ok = w_data_fwd & (w_owner == OWN_INST);
  assign data_data_ok = w_data_fwd & (w_owner == OWN_DATA);

  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;

endmodule

`default_nettype wire

// File: tb/tb_sraml_arbiter.sv
// =============================================================================
// tb_sraml_arbiter : table vectors, directed corner cases and randomized
//                    traffic checked against a transaction-level model.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_sraml_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_addr_ok, m_data_ok;

  always #5 clk = ~clk;

  sraml_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok)
  );

  typedef struct packed {
    logic        mreq;
    logic        mwr;
    logic [1:0]  msize;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        ia, da, id, dd;
    logic [31:0] ir, dr;
  } out_t;

  typedef struct {
    logic ir, dr, aok, dok;
    logic mreq;
    int   sel;      // 0 none, 1 inst fields, 2 data fields on the master port
    logic ia, da, id, dd;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  out_t last;

  // Transaction-level model: phase 0 = bus free, 1 = request waiting for
  // address acceptance, 2 = address taken, waiting for read/write data.
  int mdl_phase;
  bit mdl_owner;   // 1 = data side
  int mdl_starve;

  task automatic model_reset();
    mdl_phase = 0; mdl_owner = 0; mdl_starve = 0;
  endtask

  task automatic check_val(string name, longint act, longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(string name, out_t act, out_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic out_t sample();
    out_t a;
    a.mreq = m_req; a.mwr = m_wr; a.msize = m_size; a.maddr = m_addr;
    a.mwdata = m_wdata; a.ia = inst_addr_ok; a.da = data_addr_ok;
    a.id = inst_data_ok; a.dd = data_data_ok; a.ir = inst_rdata; a.dr = data_rdata;
    return a;
  endfunction

  function automatic out_t fields_of(bit dside);
    out_t e = '0;
    e.mreq   = 1'b1;
    e.mwr    = dside ? data_wr    : inst_wr;
    e.msize  = dside ? data_size  : inst_size;
    e.maddr  = dside ? data_addr  : inst_addr;
    e.mwdata = dside ? data_wdata : inst_wdata;
    return e;
  endfunction

  // One clock: compare outputs with the model at the falling edge, advance
  // the model, then return 1 time unit after the rising edge.
  task automatic step(string name);
    out_t e;
    bit   have, own;
    @(negedge clk);
    have = 0; own = 0;
    if (!rst) begin
      model_reset();
    end else if (mdl_phase == 0) begin
      if (data_req && !(mdl_starve == STARVE_MAX && inst_req)) begin have = 1; own = 1; end
      else if (inst_req) begin have = 1; own = 0; end
    end else if (mdl_phase == 1) begin
      have = 1; own = mdl_owner;
    end
    e = have ? fields_of(own) : '0;
    if (have && m_addr_ok) begin
      if (own) e.da = 1'b1; else e.ia = 1'b1;
      if (m_data_ok) begin if (own) e.dd = 1'b1; else e.id = 1'b1; end
    end else if (rst && mdl_phase == 2 && m_data_ok) begin
      if (mdl_owner) e.dd = 1'b1; else e.id = 1'b1;
    end
    e.ir = m_rdata; e.dr = m_rdata;
    last = sample();
    check_out(name, last, e);
    if (have) begin
      mdl_owner = own;
      if (m_addr_ok) begin
        if (!own) mdl_starve = 0;
        else if (inst_req && mdl_starve < STARVE_MAX) mdl_starve++;
        mdl_phase = m_data_ok ? 0 : 2;
      end else begin
        mdl_phase = 1;
      end
    end else if (rst && mdl_phase == 2 && m_data_ok) begin
      mdl_phase = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic set_idle_inputs();
    inst_req = 0; data_req = 0; m_addr_ok = 0; m_data_ok = 0;
    inst_wr = 0; inst_size = 2'd2; inst_addr = 32'h1000_0040; inst_wdata = 32'h1111_1111;
    data_wr = 1; data_size = 2'd1; data_addr = 32'h2000_0080; data_wdata = 32'h2222_2222;
    m_rdata = 32'h5555_AAAA;
  endtask

  // Reset with requests and handshakes active, so any leakage is visible.
  task automatic apply_reset();
    set_idle_inputs();
    inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = 1;
    rst = 0;
    @(negedge clk);
    check_val("reset_quiet", {m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
    @(posedge clk); #1;
    rst = 1;
    model_reset();
    set_idle_inputs();
  endtask

  vec_t tbl[8];

  initial begin
    out_t e;
    rst = 0;
    set_idle_inputs();

    // ---------------- table-driven vectors from reset ----------------
    tbl[0] = '{1,1,1,0, 1,2, 0,1,0,0};  // simultaneous: data wins, goes to DATA
    tbl[1] = '{1,1,0,1, 0,0, 0,0,0,1};  // DATA: data_ok to data only
    tbl[2] = '{1,0,0,0, 1,1, 0,0,0,0};  // inst wins, waits for addr
    tbl[3] = '{0,1,0,0, 1,1, 0,0,0,0};  // ADDR keeps inst owner although inst dropped
    tbl[4] = '{0,1,1,1, 1,1, 1,0,1,0};  // inst accepted and completed together
    tbl[5] = '{0,0,0,1, 0,0, 0,0,0,0};  // spurious data_ok in IDLE ignored
    tbl[6] = '{0,0,0,0, 0,0, 0,0,0,0};
    tbl[7] = '{0,1,1,1, 1,2, 0,1,0,1};  // lone data grant, both in one cycle
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      inst_req = tbl[i].ir; data_req = tbl[i].dr;
      m_addr_ok = tbl[i].aok; m_data_ok = tbl[i].dok;
      @(negedge clk);
      e = (tbl[i].sel == 0) ? '0 : fields_of(tbl[i].sel == 2);
      e.ia = tbl[i].ia; e.da = tbl[i].da; e.id = tbl[i].id; e.dd = tbl[i].dd;
      e.ir = m_rdata; e.dr = m_rdata;
      check_out($sformatf("table_%0d", i), sample(), e);
      @(posedge clk); #1;
      if (i == 0) begin
        check_val("tbl_state_data", dut.state_q, 2);
        check_val("tbl_starve_one", dut.starve_q, 1);
      end
    end
    check_val("tbl_starve_final", dut.starve_q, 0);

    // ---------------- starvation: 4 data grants, then inst ----------------
    apply_reset();
    inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = 1;
    for (int i = 0; i < 5; i++) begin
      step("starve_model");
      check_val($sformatf("starve_grant_%0d", i), {last.ia, last.da}, (i < 4) ? 2'b01 : 2'b10);
    end
    check_val("starve_cleared", dut.starve_q, 0);

    // ---------------- delayed addr_ok with inst_req rising mid-wait -------
    apply_reset();
    data_req = 1; data_wr = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) inst_req = 1;
      step("delay_model");
      check_val("delay_addr", last.maddr, 32'h2000_0080);
      check_val("delay_no_aok", {last.ia, last.da}, 0);
    end
    m_addr_ok = 1;
    step("delay_grant");
    check_val("delay_aok_data", {last.ia, last.da, last.maddr}, {2'b01, 32'h2000_0080});
    check_val("delay_state", {dut.state_q, dut.owner_q, dut.starve_q}, {2'd2, 1'b1, 3'd1});
    m_addr_ok = 0; m_data_ok = 1; inst_req = 0; data_req = 0;
    step("delay_data");
    check_val("delay_dok", {last.id, last.dd}, 2'b01);

    // ---------------- addr_ok and data_ok in the same cycle ---------------
    apply_reset();
    inst_req = 1; m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'hDEADBEEF;
    step("same_cycle_model");
    check_val("same_cycle_oks", {last.ia, last.id, last.da, last.dd}, 4'b1100);
    check_val("same_cycle_rdata", last.ir, 32'hDEADBEEF);
    check_val("same_cycle_idle", dut.state_q, 0);

    // ---------------- reset in DATA, then stray data_ok -------------------
    apply_reset();
    data_req = 1; m_addr_ok = 1;
    step("rst_mid_grant");
    check_val("rst_mid_in_data", dut.state_q, 2);
    rst = 0; m_addr_ok = 0; m_data_ok = 1; data_req = 0;
    #2;
    check_val("rst_async_state", dut.state_q, 0);
    check_val("rst_async_oks", {m_req, inst_data_ok, data_data_ok}, 0);
    @(posedge clk); #1;
    rst = 1; model_reset();
    step("rst_stray_model");
    check_val("rst_stray_dok", {last.id, last.dd}, 0);
    check_val("rst_stray_idle", dut.state_q, 0);

    // ---------------- randomized traffic vs model -------------------------
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 49) != 0);
      inst_req   = ($urandom_range(0, 2) != 0);
      data_req   = ($urandom_range(0, 2) != 0);
      inst_wr    = $urandom_range(0, 1);
      data_wr    = $urandom_range(0, 1);
      inst_size  = 2'($urandom_range(0, 3));
      data_size  = 2'($urandom_range(0, 3));
      inst_addr  = $urandom;
      data_addr  = $urandom;
      inst_wdata = $urandom;
      data_wdata = $urandom;
      m_rdata    = $urandom;
      m_addr_ok  = ($urandom_range(0, 2) == 0);
      m_data_ok  = ($urandom_range(0, 2) == 0);
      step("random");
    end
    rst = 1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
